// File: rtl/inst_rom_loader.sv
// Instruction-ROM program loader: assembles a framed little-endian byte stream into
// 32-bit ROM words, verifies an XOR checksum and releases the core on a good frame.
module inst_rom_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [31:0]           rom_wdata,
    output logic                  core_enable,
    output logic                  core_rst_n,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_L, S_LEN_H, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_e;

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d, len_new;
    logic [31:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ready_q, en_q, rstn_q, done_q, err_q;
    logic                  accept, is_sync, last_word;

    assign accept    = s_valid & ready_q;
    assign is_sync   = accept && (s_data == SYNC_BYTE);
    assign len_new   = {s_data, len_q[7:0]};
    assign last_word = (32'(addr_q) + 32'd1) == 32'(len_q);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (is_sync) begin
                    state_d = S_LEN_L;
                    csum_d  = '0;
                    addr_d  = '0;
                end
            end
            S_LEN_L: begin
                if (accept) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN_H;
                end
            end
            S_LEN_H: begin
                if (accept) begin
                    len_d = len_new;
                    if (32'(len_new) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_new == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                        addr_d  = '0;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                // Bytes arrive LSB first, so shift in from the top.
                if (accept) begin
                    word_d = {s_data, word_q[31:8]};
                    csum_d = csum_q ^ s_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) state_d = (s_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            rstn_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            ready_q <= (state_d != S_WRITE);
            en_q    <= (state_d == S_DONE);
            // Reset release trails enable by one cycle.
            rstn_q  <= en_q && (state_d == S_DONE);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign s_ready     = ready_q;
    assign rom_we      = (state_q == S_WRITE);
    assign rom_addr    = addr_q;
    assign rom_wdata   = word_q;
    assign core_enable = en_q;
    assign core_rst_n  = rstn_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: frame-level model predicts ROM writes and
// load status; a per-cycle monitor compares writes, handshake and core-release order.
module tb_inst_rom_loader;

    localparam int         AW   = 10;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic          core_enable;
    logic          core_rst_n;
    logic          load_done;
    logic          load_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW+31:0] exp_q[$];
    logic [31:0]    pay[$];
    int             wr_count = 0;
    logic [AW-1:0]  last_waddr = '0;
    logic [31:0]    last_wdata = '0;
    int             edges_since_rst = 0;
    logic           prev_en = 1'b0;
    logic           prev_rstn = 1'b0;

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_wdata   (rom_wdata),
        .core_enable (core_enable),
        .core_rst_n  (core_rst_n),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) edges_since_rst <= 0;
        else     edges_since_rst <= edges_since_rst + 1;
    end

    always @(negedge clk) begin : monitor
        logic [AW+31:0] e;
        if (!rst) begin
            if (rom_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rom_we", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rom_addr", rom_addr, e[AW+31:32]);
                    check("rom_wdata", rom_wdata, e[31:0]);
                end
                wr_count   <= wr_count + 1;
                last_waddr <= rom_addr;
                last_wdata <= rom_wdata;
            end
            if (edges_since_rst > 0) check("s_ready_vs_write", s_ready, !rom_we);
            if (core_rst_n) check("rst_n_implies_enable", core_enable, 1);
            if (core_rst_n && !prev_rstn) check("enable_one_cycle_before_rst_n", prev_en, 1);
            check("done_err_exclusive", load_done & load_err, 0);
            prev_en   <= core_enable;
            prev_rstn <= core_rst_n;
        end else begin
            prev_en   <= 1'b0;
            prev_rstn <= 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b, input int min_gap, input int max_gap);
        send_byte(b);
        idle(int'($urandom_range(max_gap, min_gap)));
    endtask

    function automatic logic [7:0] model_csum();
        logic [31:0] x = '0;
        foreach (pay[i]) x ^= pay[i];
        return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
    endfunction

    // csum_mode: -1 correct checksum, -2 random wrong checksum, 0..255 literal byte.
    task automatic send_frame(input bit with_sync, input int min_gap, input int max_gap,
                              input int csum_mode);
        logic [7:0]  cs;
        logic [15:0] len;
        logic [31:0] w;
        len = 16'(pay.size());
        cs  = model_csum();
        if (csum_mode == -2) cs = cs ^ 8'(1 + $urandom_range(254, 0));
        else if (csum_mode >= 0) cs = 8'(csum_mode);
        foreach (pay[i]) exp_q.push_back({AW'(i), pay[i]});
        if (with_sync) put(SYNC, min_gap, max_gap);
        put(len[7:0], min_gap, max_gap);
        put(len[15:8], min_gap, max_gap);
        foreach (pay[i]) begin
            w = pay[i];
            for (int k = 0; k < 4; k++) put(w[8*k +: 8], min_gap, max_gap);
        end
        send_byte(cs);
    endtask

    // Called right after the frame's final accepted byte.
    task automatic check_status(input string tag, input bit good);
        check({tag, "_load_done"}, load_done, good);
        check({tag, "_load_err"}, load_err, !good);
        check({tag, "_core_enable"}, core_enable, good);
        check({tag, "_core_rst_n_held"}, core_rst_n, 0);
        check({tag, "_writes_pending"}, exp_q.size(), 0);
        if (good) begin
            idle(1);
            check({tag, "_core_rst_n_released"}, core_rst_n, 1);
            check({tag, "_core_enable_kept"}, core_enable, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_rom_we"}, rom_we, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_rom_wdata"}, rom_wdata, 0);
        check({tag, "_core_enable"}, core_enable, 0);
        check({tag, "_core_rst_n"}, core_rst_n, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] big;
        logic [7:0]  g;
        logic [31:0] w;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", s_ready, 0);
        idle(1);
        check("ready_after_first_edge", s_ready, 1);

        // Single-word frame A5 01 00 13 05 10 00 06.
        pay = '{32'h00100513};
        check("t1_model_csum", model_csum(), 8'h06);
        base = wr_count;
        send_frame(1'b1, 0, 0, -1);
        check_status("t1", 1'b1);
        check("t1_write_count", wr_count - base, 1);
        check("t1_waddr", last_waddr, 0);
        check("t1_wdata", last_wdata, 32'h00100513);

        // SYNC after DONE re-holds the core on the next edge.
        send_byte(SYNC);
        check("resync_core_enable", core_enable, 0);
        check("resync_core_rst_n", core_rst_n, 0);
        check("resync_load_done", load_done, 0);

        // Three words with s_valid toggling every cycle.
        pay  = '{32'hDEADBEEF, 32'h01234567, 32'hA5A5005A};
        base = wr_count;
        send_frame(1'b0, 1, 1, -1);
        check_status("t2", 1'b1);
        check("t2_write_count", wr_count - base, 3);
        check("t2_last_waddr", last_waddr, 2);

        // Wrong checksum 00 (correct is 44).
        pay = '{32'h44332211};
        check("t3_model_csum", model_csum(), 8'h44);
        send_frame(1'b1, 0, 0, 0);
        check_status("t3", 1'b0);
        check("t3_wdata", last_wdata, 32'h44332211);

        // Empty frame, then oversize length 0x0401.
        pay.delete();
        base = wr_count;
        send_frame(1'b1, 0, 0, -1);
        check_status("t4_empty", 1'b1);
        check("t4_empty_writes", wr_count - base, 0);
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h04);
        check_status("t4_oversize", 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        idle(2);
        check("t4_dropped_err", load_err, 1);
        check("t4_dropped_writes", wr_count - base, 0);

        // Garbage before SYNC and SYNC bytes inside the payload.
        send_byte(8'hFF);
        send_byte(8'h12);
        pay  = '{32'h11A52233, 32'hA5A5A5A5};
        base = wr_count;
        send_frame(1'b1, 0, 2, -1);
        check_status("t5", 1'b1);
        check("t5_write_count", wr_count - base, 2);

        // Reset after two of four words, then a full reload from address 0.
        pay  = '{$urandom, $urandom, $urandom, $urandom};
        base = wr_count;
        exp_q.push_back({AW'(0), pay[0]});
        exp_q.push_back({AW'(1), pay[1]});
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 2; i++) begin
            w = pay[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t6_midload");
        check("t6_partial_writes", wr_count - base, 2);
        idle(2);
        rst = 1'b0;
        idle(1);
        send_frame(1'b1, 0, 1, -1);
        check_status("t6_reload", 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t6_done_reset");
        idle(2);
        rst = 1'b0;
        idle(1);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            for (int n = 0; n < int'($urandom_range(3, 0)); n++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h5A;
                send_byte(g);
            end
            if ($urandom_range(7, 0) == 0) begin
                big = 16'($urandom_range(65535, 1025));
                send_byte(SYNC);
                send_byte(big[7:0]);
                send_byte(big[15:8]);
                check_status("rnd_oversize", 1'b0);
            end else begin
                pay.delete();
                for (int i = 0; i < int'($urandom_range(6, 0)); i++) pay.push_back($urandom);
                if ($urandom_range(3, 0) == 0) begin
                    send_frame(1'b1, 0, 3, -2);
                    check_status("rnd_bad", 1'b0);
                end else begin
                    send_frame(1'b1, 0, 3, -1);
                    check_status("rnd_good", 1'b1);
                end
            end
        end
        idle(3);
        check("final_writes_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
